// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package wb_pkg;

   localparam int ADDR_W_DEF = 5;
   localparam int DATA_W_DEF = 32;
   localparam int CNT_W      = 4;

   typedef enum logic [1:0] {SRC_NONE, SRC_PIPE, SRC_MDU, SRC_LSU} wb_src_e;
   typedef enum logic {ST_NORMAL, ST_FORCE} arb_state_e;

   localparam logic [ADDR_W_DEF-1:0] REG_ZERO = '0;

endpackage

// File: rtl/wb_rr_pick2.sv
// Two-way round-robin picker: ptr chooses the winner only when both request.
module wb_rr_pick2 (
   input  logic [1:0] req,
   input  logic       ptr,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = req;
      if (&req) gnt = ptr ? 2'b10 : 2'b01;
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline first, MDU/LSU round-robin, starvation-forced slot.
// Optional WB_STATS_EN adds stat_conflict / stat_forced counters.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_NORMAL | pipeline has priority; secondaries use idle pipeline slots
// ST_FORCE  | pipeline stalled one cycle; a waiting secondary retires
module wb_port_arbiter
   import wb_pkg::*;
#(
   parameter int DATA_W       = DATA_W_DEF,
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pipe_valid,
   input  logic [ADDR_W-1:0] pipe_rd,
   input  logic [DATA_W-1:0] pipe_data,
   output logic              pipe_stall,
   input  logic              mdu_valid,
   input  logic [ADDR_W-1:0] mdu_rd,
   input  logic [DATA_W-1:0] mdu_data,
   output logic              mdu_ready,
   input  logic              lsu_valid,
   input  logic [ADDR_W-1:0] lsu_rd,
   input  logic [DATA_W-1:0] lsu_data,
   output logic              lsu_ready,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata
`ifdef WB_STATS_EN
   ,
   output logic [31:0]       stat_conflict,
   output logic [31:0]       stat_forced
`endif
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   arb_state_e        state_q, state_d;
   logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic              rr_ptr_q, rr_ptr_d;
   logic              rf_we_q, rf_we_d;
   logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
   logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

   logic [1:0]        sec_req, sec_gnt;
   logic              sec_slot;
   wb_src_e           win_src;
   logic [ADDR_W-1:0] win_rd;
   logic [DATA_W-1:0] win_data;

   assign sec_req = {lsu_valid, mdu_valid};

   wb_rr_pick2 u_pick (
      .req (sec_req),
      .ptr (rr_ptr_q),
      .gnt (sec_gnt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_NORMAL;
         wait_cnt_q <= '0;
         rr_ptr_q   <= 1'b0;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         rr_ptr_q   <= rr_ptr_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      rr_ptr_d   = rr_ptr_q;
      win_src    = SRC_NONE;
      win_rd     = pipe_rd;
      win_data   = pipe_data;

      sec_slot = (state_q == ST_FORCE) || !pipe_valid;
      if (!sec_slot)       win_src = SRC_PIPE;
      else if (sec_gnt[0]) win_src = SRC_MDU;
      else if (sec_gnt[1]) win_src = SRC_LSU;

      case (win_src)
         SRC_MDU: begin win_rd = mdu_rd; win_data = mdu_data; end
         SRC_LSU: begin win_rd = lsu_rd; win_data = lsu_data; end
         default: ;
      endcase

      if (win_src == SRC_MDU || win_src == SRC_LSU) begin
         wait_cnt_d = '0;
         rr_ptr_d   = (win_src == SRC_MDU);
      end else if (|sec_req) begin
         wait_cnt_d = (wait_cnt_q == LIMIT) ? LIMIT : wait_cnt_q + CNT_W'(1);
      end else begin
         wait_cnt_d = '0;
      end

      case (state_q)
         ST_NORMAL: if (wait_cnt_d == LIMIT) state_d = ST_FORCE;
         ST_FORCE:  state_d = ST_NORMAL;
         default:   state_d = ST_NORMAL;
      endcase

      // a grant to x0 still loads the address/data registers but never writes
      rf_we_d    = (win_src != SRC_NONE) && (win_rd != ADDR_W'(REG_ZERO));
      rf_waddr_d = (win_src != SRC_NONE) ? win_rd   : rf_waddr_q;
      rf_wdata_d = (win_src != SRC_NONE) ? win_data : rf_wdata_q;
   end

   assign pipe_stall = (state_q == ST_FORCE);
   assign mdu_ready  = rst_n && (win_src == SRC_MDU);
   assign lsu_ready  = rst_n && (win_src == SRC_LSU);
   assign rf_we      = rf_we_q;
   assign rf_waddr   = rf_waddr_q;
   assign rf_wdata   = rf_wdata_q;

`ifdef WB_STATS_EN
   logic [31:0] stat_conflict_q, stat_conflict_d;
   logic [31:0] stat_forced_q, stat_forced_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_conflict_q <= '0;
         stat_forced_q   <= '0;
      end else begin
         stat_conflict_q <= stat_conflict_d;
         stat_forced_q   <= stat_forced_d;
      end
   end

   always_comb begin
      stat_conflict_d = stat_conflict_q;
      stat_forced_d   = stat_forced_q;
      if (state_q == ST_NORMAL && pipe_valid && |sec_req)
         stat_conflict_d = stat_conflict_q + 32'd1;
      if (state_q == ST_FORCE)
         stat_forced_d = stat_forced_q + 32'd1;
   end

   assign stat_conflict = stat_conflict_q;
   assign stat_forced   = stat_forced_q;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized scoreboard bench for wb_port_arbiter; also checks stats when WB_STATS_EN is defined.
module tb_wb_port_arbiter;

   localparam int LIMIT = 4;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pipe_valid = 1'b0, mdu_valid = 1'b0, lsu_valid = 1'b0;
   logic [4:0]  pipe_rd = '0, mdu_rd = '0, lsu_rd = '0;
   logic [31:0] pipe_data = '0, mdu_data = '0, lsu_data = '0;
   logic        pipe_stall, mdu_ready, lsu_ready, rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
`ifdef WB_STATS_EN
   logic [31:0] stat_conflict, stat_forced;
`endif

   int checks = 0;
   int failures = 0;
   wr_t exp_q[$];

   // reference model: forced-slot flag, consecutive-denial count, round-robin turn
   bit  m_force = 0;
   int  m_wait = 0;
   int  m_rr = 0;
   int  m_conf = 0;
   int  m_forc = 0;
   bit  acc_mdu = 0, acc_lsu = 0;

   always #5 clk = ~clk;

   wb_port_arbiter #(.DATA_W(32), .ADDR_W(5), .STARVE_LIMIT(LIMIT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pipe_valid (pipe_valid),
      .pipe_rd    (pipe_rd),
      .pipe_data  (pipe_data),
      .pipe_stall (pipe_stall),
      .mdu_valid  (mdu_valid),
      .mdu_rd     (mdu_rd),
      .mdu_data   (mdu_data),
      .mdu_ready  (mdu_ready),
      .lsu_valid  (lsu_valid),
      .lsu_rd     (lsu_rd),
      .lsu_data   (lsu_data),
      .lsu_ready  (lsu_ready),
      .rf_we      (rf_we),
      .rf_waddr   (rf_waddr),
      .rf_wdata   (rf_wdata)
`ifdef WB_STATS_EN
      ,
      .stat_conflict (stat_conflict),
      .stat_forced   (stat_forced)
`endif
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // monitor: every write the DUT presents must match the oldest expected write
   always @(negedge clk) begin
      if (rst_n && rf_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write actual addr=%0d data=%0h expected none", rf_waddr, rf_wdata);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("wr_addr", 64'(rf_waddr), 64'(e.a));
            chk("wr_data", 64'(rf_wdata), 64'(e.d));
         end
      end
   end

   // called just after a rising edge: sources hold until accepted, pipe holds while stalled
   task automatic drive_next(input int p_pipe, input int p_mdu, input int p_lsu);
      if (!(mdu_valid && !acc_mdu)) begin
         mdu_valid = ($urandom_range(99) < p_mdu);
         mdu_rd    = 5'($urandom_range(31));
         mdu_data  = $urandom;
      end
      if (!(lsu_valid && !acc_lsu)) begin
         lsu_valid = ($urandom_range(99) < p_lsu);
         lsu_rd    = 5'($urandom_range(31));
         lsu_data  = $urandom;
      end
      if (!m_force) begin
         pipe_valid = ($urandom_range(99) < p_pipe);
         pipe_rd    = 5'($urandom_range(31));
         pipe_data  = $urandom;
      end
   endtask

   task automatic eval_cycle();
      int   sel;
      logic [4:0]  rd;
      logic [31:0] dt;
      #1;
      if (!m_force && pipe_valid)   sel = 1;
      else if (mdu_valid && lsu_valid) sel = (m_rr == 0) ? 2 : 3;
      else if (mdu_valid)           sel = 2;
      else if (lsu_valid)           sel = 3;
      else                          sel = 0;
      chk("pipe_stall", 64'(pipe_stall), 64'(m_force));
      chk("mdu_ready", 64'(mdu_ready), 64'(sel == 2));
      chk("lsu_ready", 64'(lsu_ready), 64'(sel == 3));
      if (!m_force && pipe_valid && (mdu_valid || lsu_valid)) m_conf++;
      if (m_force) m_forc++;
      rd = (sel == 1) ? pipe_rd : (sel == 2) ? mdu_rd : lsu_rd;
      dt = (sel == 1) ? pipe_data : (sel == 2) ? mdu_data : lsu_data;
      if (sel != 0 && rd != 5'd0) exp_q.push_back('{a: rd, d: dt});
      if (sel >= 2) begin
         m_rr   = (sel == 2) ? 1 : 0;
         m_wait = 0;
      end else if (mdu_valid || lsu_valid) begin
         m_wait = (m_wait + 1 > LIMIT) ? LIMIT : m_wait + 1;
      end else begin
         m_wait = 0;
      end
      m_force = !m_force && (m_wait == LIMIT);
      acc_mdu = (sel == 2);
      acc_lsu = (sel == 3);
      @(posedge clk);
      #1;
   endtask

   task automatic run_phase(input int n, input int p_pipe, input int p_mdu, input int p_lsu);
      for (int i = 0; i < n; i++) begin
         drive_next(p_pipe, p_mdu, p_lsu);
         eval_cycle();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int guard;
      mdu_valid = 1'b1;
      lsu_valid = 1'b1;
      #12;
      chk("rst_mdu_ready", 64'(mdu_ready), 64'd0);
      chk("rst_lsu_ready", 64'(lsu_ready), 64'd0);
      chk("rst_pipe_stall", 64'(pipe_stall), 64'd0);
      chk("rst_rf_we", 64'(rf_we), 64'd0);
      chk("rst_rf_waddr", 64'(rf_waddr), 64'd0);
      chk("rst_rf_wdata", 64'(rf_wdata), 64'd0);
      mdu_valid = 1'b0;
      lsu_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      run_phase(6, 100, 0, 0);
      run_phase(10, 0, 100, 100);
      run_phase(20, 100, 100, 0);
      run_phase(30, 100, 100, 100);
      run_phase(20, 0, 0, 100);

      // drive into a forced slot, then reset in the middle of it
      guard = 0;
      while (!m_force && guard < 20) begin
         drive_next(100, 100, 0);
         eval_cycle();
         guard++;
      end
      checks++;
      if (!m_force) begin
         failures++;
         $display("FAIL reach_force actual=no_forced_slot required=forced_slot_within_20");
      end
      drive_next(100, 100, 0);
      #1;
      chk("pre_rst_stall", 64'(pipe_stall), 64'(m_force));
      rst_n = 1'b0;
      #1;
      chk("midforce_stall", 64'(pipe_stall), 64'd0);
      chk("midforce_rf_we", 64'(rf_we), 64'd0);
      chk("midforce_mdu_ready", 64'(mdu_ready), 64'd0);
      exp_q.delete();
      m_force = 0; m_wait = 0; m_rr = 0; m_conf = 0; m_forc = 0;
      acc_mdu = 0; acc_lsu = 0;
      @(posedge clk);
      #1;
      chk("midforce_rf_waddr", 64'(rf_waddr), 64'd0);
      rst_n = 1'b1;
      run_phase(LIMIT + 3, 100, 100, 0);

      run_phase(400, 50, 40, 40);
      run_phase(300, 80, 60, 60);
      run_phase(4, 0, 0, 0);
      chk("write_queue_empty", 64'(exp_q.size()), 64'd0);
`ifdef WB_STATS_EN
      chk("stat_conflict", 64'(stat_conflict), 64'(m_conf));
      chk("stat_forced", 64'(stat_forced), 64'(m_forc));
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
